// File: rtl/seg_display_pkg.sv
// Shared types, segment encodings and sizing helpers for the multiplexed
// seven-segment display controller.
package seg_display_pkg;

   // Active-low segment patterns, bit 0 = segment a .. bit 6 = segment g.
   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_MINUS = 7'b0111111;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_COMMIT
   } state_e;

   // Number of decimal digits needed to print 2**width.
   function automatic int bcd_digits(input int width);
      longint unsigned v;
      int n;
      v = 64'd1 << width;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         if (v != 64'd0) begin
            n++;
            v = v / 64'd10;
         end
      end
      return n;
   endfunction

   function automatic logic [6:0] seg_encode(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = SEG_0;
         4'd1:    s = SEG_1;
         4'd2:    s = SEG_2;
         4'd3:    s = SEG_3;
         4'd4:    s = SEG_4;
         4'd5:    s = SEG_5;
         4'd6:    s = SEG_6;
         4'd7:    s = SEG_7;
         4'd8:    s = SEG_8;
         4'd9:    s = SEG_9;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/seg_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one add-3/shift step per cycle, result
// held in COMMIT for one cycle, restartable directly from COMMIT.
module bin2bcd_seq
   import seg_display_pkg::*;
#(
   parameter int DATA_W     = 13,
   parameter int BCD_DIGITS = 4
) (
   input  logic                    clk_in,
   input  logic                    rst,
   input  logic                    start,
   input  logic [DATA_W-1:0]       magnitude,
   output logic                    busy,
   output logic                    done,
   output logic [4*BCD_DIGITS-1:0] bcd
);

   localparam int              CNT_W = $clog2(DATA_W);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

   state_e                  state_q, state_d;
   logic [DATA_W-1:0]       bin_q, bin_d;
   logic [4*BCD_DIGITS-1:0] bcd_q, bcd_d, adj;
   logic [CNT_W-1:0]        cnt_q, cnt_d;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < BCD_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // NOTE: every output of a combinational block gets a default first so no path infers a latch.
   always_comb begin
      state_d = state_q;
      bin_d   = bin_q;
      bcd_d   = bcd_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE, ST_COMMIT: begin
            state_d = ST_IDLE;
            if (start) begin
               state_d = ST_SHIFT;
               bin_d   = magnitude;
               bcd_d   = '0;
               cnt_d   = '0;
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {adj, bin_q} << 1;
            cnt_d          = cnt_q + 1'b1;
            if (cnt_q == LAST) state_d = ST_COMMIT;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk_in) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   // NOTE: the datapath is left unreset; it is always reloaded on start before it is read.
   always_ff @(posedge clk_in) begin
      bin_q <= bin_d;
      bcd_q <= bcd_d;
      cnt_q <= cnt_d;
   end

   assign busy = (state_q != ST_IDLE);
   assign done = (state_q == ST_COMMIT);
   assign bcd  = bcd_q;

endmodule

// File: rtl/seg_display_ctrl.sv
// Multiplexed seven-segment display controller: valid/busy load with a one-deep
// pending slot, signed/overflow/blanking rendering and a common-anode scanner.
module seg_display_ctrl
   import seg_display_pkg::*;
#(
   parameter int NUM_DIGITS  = 4,
   parameter int DATA_W      = 13,
   parameter int REFRESH_DIV = 250000,
   parameter bit BLANK_LZ    = 1'b1
) (
   input  logic                  clk_in,
   input  logic                  rst,
   input  logic [DATA_W-1:0]     num,
   input  logic                  num_valid,
   input  logic                  signed_mode,
   input  logic [NUM_DIGITS-1:0] dp_mask,
   output logic                  busy,
   output logic                  done,
   output logic [NUM_DIGITS-1:0] Anode,
   output logic [6:0]            seg,
   output logic                  dp
);

   localparam int BCD_DIGITS = bcd_digits(DATA_W);
   localparam int EXT_DIGITS = (BCD_DIGITS > NUM_DIGITS) ? BCD_DIGITS : NUM_DIGITS;
   localparam int IDX_W      = $clog2(NUM_DIGITS);
   localparam int REF_W      = $clog2(REFRESH_DIV);

   logic                    eng_busy, eng_done, eng_start;
   logic [4*BCD_DIGITS-1:0] eng_bcd;
   logic [DATA_W-1:0]       start_num, start_mag;
   logic                    start_signed, start_neg;

   logic                    pend_q, pend_d;
   logic [DATA_W-1:0]       pend_num_q, pend_num_d;
   logic                    pend_signed_q, pend_signed_d;
   logic                    conv_neg_q, conv_neg_d;

   logic [4*EXT_DIGITS-1:0] bcd_ext;
   logic                    ovf;
   int                      avail;
   logic [4*NUM_DIGITS-1:0] disp_bcd_q, disp_bcd_d;
   logic                    disp_neg_q, disp_neg_d;
   logic                    disp_ovf_q, disp_ovf_d;

   logic [REF_W-1:0]        ref_cnt_q, ref_cnt_d;
   logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
   logic [NUM_DIGITS-1:0]   anode_q, anode_d;
   logic [6:0]              seg_q, seg_d;
   logic                    dp_q, dp_d;
   int                      msd, cur;
   logic [3:0]              digit;

   // A request arriving in COMMIT outranks the older pending entry and starts at once.
   always_comb begin
      pend_d        = pend_q;
      pend_num_d    = pend_num_q;
      pend_signed_d = pend_signed_q;
      eng_start     = 1'b0;
      start_num     = num;
      start_signed  = signed_mode;
      if (!eng_busy) begin
         eng_start = num_valid;
      end else if (eng_done) begin
         eng_start = num_valid | pend_q;
         pend_d    = 1'b0;
         if (!num_valid) begin
            start_num    = pend_num_q;
            start_signed = pend_signed_q;
         end
      end else if (num_valid) begin
         pend_d        = 1'b1;
         pend_num_d    = num;
         pend_signed_d = signed_mode;
      end
      start_neg  = start_signed & start_num[DATA_W-1];
      start_mag  = start_neg ? DATA_W'(-{start_num[DATA_W-1], start_num}) : start_num;
      conv_neg_d = eng_start ? start_neg : conv_neg_q;
   end

   bin2bcd_seq #(
      .DATA_W     (DATA_W),
      .BCD_DIGITS (BCD_DIGITS)
   ) u_bin2bcd (
      .clk_in    (clk_in),
      .rst       (rst),
      .start     (eng_start),
      .magnitude (start_mag),
      .busy      (eng_busy),
      .done      (eng_done),
      .bcd       (eng_bcd)
   );

   always_comb begin
      bcd_ext = (4*EXT_DIGITS)'(eng_bcd);
      avail   = conv_neg_q ? NUM_DIGITS - 1 : NUM_DIGITS;
      ovf     = 1'b0;
      for (int i = 0; i < EXT_DIGITS; i++) begin
         if (i >= avail && bcd_ext[4*i +: 4] != 4'd0) ovf = 1'b1;
      end
      disp_bcd_d = disp_bcd_q;
      disp_neg_d = disp_neg_q;
      disp_ovf_d = disp_ovf_q;
      if (eng_done) begin
         disp_bcd_d = bcd_ext[4*NUM_DIGITS-1:0];
         disp_neg_d = conv_neg_q;
         disp_ovf_d = ovf;
      end
   end

   always_comb begin
      ref_cnt_d  = ref_cnt_q + 1'b1;
      scan_idx_d = scan_idx_q;
      if (ref_cnt_q == REF_W'(REFRESH_DIV - 1)) begin
         ref_cnt_d  = '0;
         scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
      end
   end

   // msd is the most significant nonzero digit; the units digit (0) always shows.
   always_comb begin
      msd = 0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (disp_bcd_q[4*i +: 4] != 4'd0) msd = i;
      end
      cur   = int'(scan_idx_q);
      digit = disp_bcd_q[4*cur +: 4];
      if (disp_ovf_q) begin
         seg_d = SEG_MINUS;
      end else if (BLANK_LZ) begin
         if (cur <= msd)                       seg_d = seg_encode(digit);
         else if (disp_neg_q && cur == msd + 1) seg_d = SEG_MINUS;
         else                                  seg_d = SEG_BLANK;
      end else if (disp_neg_q && cur == NUM_DIGITS - 1) begin
         seg_d = SEG_MINUS;
      end else begin
         seg_d = seg_encode(digit);
      end
      anode_d = ~(NUM_DIGITS'(1) << scan_idx_q);
      dp_d    = ~dp_mask[scan_idx_q];
   end

   always_ff @(posedge clk_in) begin
      if (rst) begin
         pend_q     <= 1'b0;
         conv_neg_q <= 1'b0;
         disp_bcd_q <= '0;
         disp_neg_q <= 1'b0;
         disp_ovf_q <= 1'b0;
         ref_cnt_q  <= '0;
         scan_idx_q <= '0;
         anode_q    <= ~NUM_DIGITS'(1);
         seg_q      <= SEG_0;
         dp_q       <= 1'b1;
      end else begin
         pend_q     <= pend_d;
         conv_neg_q <= conv_neg_d;
         disp_bcd_q <= disp_bcd_d;
         disp_neg_q <= disp_neg_d;
         disp_ovf_q <= disp_ovf_d;
         ref_cnt_q  <= ref_cnt_d;
         scan_idx_q <= scan_idx_d;
         anode_q    <= anode_d;
         seg_q      <= seg_d;
         dp_q       <= dp_d;
      end
   end

   always_ff @(posedge clk_in) begin
      pend_num_q    <= pend_num_d;
      pend_signed_q <= pend_signed_d;
   end

   assign busy  = eng_busy;
   assign done  = eng_done;
   assign Anode = anode_q;
   assign seg   = seg_q;
   assign dp    = dp_q;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Directed bench for seg_display_ctrl: a BLANK_LZ=1 and a BLANK_LZ=0 instance
// share all inputs; expected values are hand-computed segment patterns.
module tb_seg_display_ctrl;
   import seg_display_pkg::*;

   localparam int ND = 4;
   localparam int DW = 13;
   localparam int RD = 4;

   logic          clk_in      = 1'b0;
   logic          rst         = 1'b1;
   logic          num_valid   = 1'b0;
   logic          signed_mode = 1'b0;
   logic [DW-1:0] num         = '0;
   logic [ND-1:0] dp_mask     = '0;

   logic          busy, done, dp;
   logic [ND-1:0] anode;
   logic [6:0]    seg;
   logic          busy_nb, done_nb, dp_nb;
   logic [ND-1:0] anode_nb;
   logic [6:0]    seg_nb;

   int checks   = 0;
   int failures = 0;
   int six_seen = 0;
   int dones    = 0;

   always #5 clk_in = ~clk_in;

   seg_display_ctrl #(
      .NUM_DIGITS (ND), .DATA_W (DW), .REFRESH_DIV (RD), .BLANK_LZ (1'b1)
   ) dut (
      .clk_in (clk_in), .rst (rst), .num (num), .num_valid (num_valid),
      .signed_mode (signed_mode), .dp_mask (dp_mask), .busy (busy), .done (done),
      .Anode (anode), .seg (seg), .dp (dp)
   );

   seg_display_ctrl #(
      .NUM_DIGITS (ND), .DATA_W (DW), .REFRESH_DIV (RD), .BLANK_LZ (1'b0)
   ) dut_nb (
      .clk_in (clk_in), .rst (rst), .num (num), .num_valid (num_valid),
      .signed_mode (signed_mode), .dp_mask (dp_mask), .busy (busy_nb), .done (done_nb),
      .Anode (anode_nb), .seg (seg_nb), .dp (dp_nb)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic wait_anode(input logic [ND-1:0] target, input string tag);
      int n = 0;
      while (anode !== target && n < 4*RD*ND) begin
         tick();
         n++;
      end
      check({tag, "_anode"}, anode, target);
   endtask

   task automatic scan_check(input logic [ND-1:0] target, input logic [6:0] exp_seg,
                             input logic [6:0] exp_seg_nb, input string tag);
      wait_anode(target, tag);
      check({tag, "_seg"}, seg, exp_seg);
      check({tag, "_anode_nb"}, anode_nb, target);
      check({tag, "_seg_nb"}, seg_nb, exp_seg_nb);
   endtask

   task automatic load(input logic [DW-1:0] value, input logic sgn);
      num         = value;
      signed_mode = sgn;
      num_valid   = 1'b1;
      tick();
      num_valid   = 1'b0;
   endtask

   // Waits for done, then steps past the commit edge and the output-register edge.
   task automatic wait_done(input string tag);
      int n = 0;
      while (done !== 1'b1 && n < 40) begin
         tick();
         n++;
      end
      check(tag, done, 1'b1);
      tick();
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      // 1. Reset state and first scan step.
      tick();
      tick();
      rst = 1'b0;
      check("rst_anode", anode, 4'b1110);
      check("rst_seg", seg, SEG_0);
      check("rst_dp", dp, 1'b1);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_busy_nb", busy_nb, 1'b0);
      check("rst_done_nb", done_nb, 1'b0);
      check("rst_dp_nb", dp_nb, 1'b1);
      repeat (5) tick();
      check("scan1_anode", anode, 4'b1101);
      check("scan1_seg", seg, SEG_BLANK);
      check("scan1_dp", dp, 1'b1);

      // 2. 1234 unsigned: 14 busy cycles, done on the last one.
      num       = 13'd1234;
      num_valid = 1'b1;
      tick();
      num_valid = 1'b0;
      for (int i = 0; i < 14; i++) begin
         check("t2_busy", busy, 1'b1);
         check("t2_done", done, (i == 13));
         tick();
      end
      check("t2_busy_end", busy, 1'b0);
      check("t2_done_end", done, 1'b0);
      tick();
      scan_check(4'b1110, SEG_4, SEG_4, "t2_d0");
      scan_check(4'b1101, SEG_3, SEG_3, "t2_d1");
      scan_check(4'b1011, SEG_2, SEG_2, "t2_d2");
      scan_check(4'b0111, SEG_1, SEG_1, "t2_d3");

      // 3. -42 signed: floating sign vs leftmost sign.
      load(13'h1FD6, 1'b1);
      wait_done("t3_done");
      scan_check(4'b1110, SEG_2, SEG_2, "t3_d0");
      scan_check(4'b1101, SEG_4, SEG_4, "t3_d1");
      scan_check(4'b1011, SEG_MINUS, SEG_0, "t3_d2");
      scan_check(4'b0111, SEG_BLANK, SEG_MINUS, "t3_d3");

      // 4. Most negative value overflows; full-scale unsigned does not.
      load(13'h1000, 1'b1);
      wait_done("t4a_done");
      scan_check(4'b1110, SEG_MINUS, SEG_MINUS, "t4a_d0");
      scan_check(4'b1101, SEG_MINUS, SEG_MINUS, "t4a_d1");
      scan_check(4'b1011, SEG_MINUS, SEG_MINUS, "t4a_d2");
      scan_check(4'b0111, SEG_MINUS, SEG_MINUS, "t4a_d3");
      load(13'd8191, 1'b0);
      wait_done("t4b_done");
      scan_check(4'b1110, SEG_1, SEG_1, "t4b_d0");
      scan_check(4'b1101, SEG_9, SEG_9, "t4b_d1");
      scan_check(4'b1011, SEG_1, SEG_1, "t4b_d2");
      scan_check(4'b0111, SEG_8, SEG_8, "t4b_d3");

      // 5. Pending slot: 6 is overwritten by 7 before it can start.
      load(13'd5, 1'b0);
      tick();
      load(13'd6, 1'b0);
      tick();
      load(13'd7, 1'b0);
      begin
         int n = 0;
         while (done !== 1'b1 && n < 40) begin
            tick();
            n++;
         end
      end
      check("t5_done1", done, 1'b1);
      if (done === 1'b1) dones++;
      tick();
      check("t5_chain_busy", busy, 1'b1);
      check("t5_chain_done", done, 1'b0);
      tick();
      check("t5_first_val", seg, (anode === 4'b1110) ? SEG_5 : SEG_BLANK);
      begin
         int n = 0;
         while (done !== 1'b1 && n < 40) begin
            if (seg === SEG_6) six_seen++;
            tick();
            n++;
         end
      end
      check("t5_done2", done, 1'b1);
      if (done === 1'b1) dones++;
      check("t5_done_count", dones, 2);
      tick();
      tick();
      scan_check(4'b1110, SEG_7, SEG_7, "t5_d0");
      scan_check(4'b1101, SEG_BLANK, SEG_0, "t5_d1");
      check("t5_six_never", six_seen, 0);

      // 6. Reset mid-conversion, then decimal point on digit 1.
      load(13'd99, 1'b0);
      repeat (4) tick();
      check("t6_busy_pre", busy, 1'b1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy_rst", busy, 1'b0);
      check("t6_done_rst", done, 1'b0);
      dp_mask = 4'b0010;
      dones   = 0;
      for (int i = 0; i < 20; i++) begin
         if (done === 1'b1) dones++;
         tick();
      end
      check("t6_no_done", dones, 0);
      scan_check(4'b1110, SEG_0, SEG_0, "t6_d0");
      check("t6_dp0", dp, 1'b1);
      scan_check(4'b1101, SEG_BLANK, SEG_0, "t6_d1");
      check("t6_dp1", dp, 1'b0);
      check("t6_dp1_nb", dp_nb, 1'b0);
      scan_check(4'b1011, SEG_BLANK, SEG_0, "t6_d2");
      check("t6_dp2", dp, 1'b1);
      scan_check(4'b0111, SEG_BLANK, SEG_0, "t6_d3");
      check("t6_dp3", dp, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
